huffman_dec: RTL and testbench

HUFFMAN_DEC -- requirements
Module: huffman_dec

---
 rtl/huffman_dec.sv | 190 +++++++++++++++++++
 tb/tb_huffman_dec.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/huffman_dec.sv
// Serial Huffman decoder with a loadable six-entry code table.
// Bits arrive MSB first; a hit emits the symbol index one cycle later.
module huffman_dec (
    input  logic       clk,
    input  logic       reset,
    input  logic       code_valid,
    input  logic [7:0] HC1,
    input  logic [7:0] HC2,
    input  logic [7:0] HC3,
    input  logic [7:0] HC4,
    input  logic [7:0] HC5,
    input  logic [7:0] HC6,
    input  logic [7:0] M1,
    input  logic [7:0] M2,
    input  logic [7:0] M3,
    input  logic [7:0] M4,
    input  logic [7:0] M5,
    input  logic [7:0] M6,
    input  logic       bit_valid,
    input  logic       bit_in,
    output logic       table_ok,
    output logic       sym_valid,
    output logic [7:0] sym_out,
    output logic       err,
    output logic [7:0] sym_cnt
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [7:0] r_hc [0:5];
    logic [7:0] r_m  [0:5];
    logic [7:0] w_hc_in [0:5];
    logic [7:0] w_m_in  [0:5];

    logic [7:0] r_acc;
    logic [3:0] r_len;
    logic       r_sym_valid;
    logic       r_err;
    logic [7:0] r_sym_out;
    logic [7:0] r_sym_cnt;

    logic       w_shift;
    logic [7:0] w_acc_nxt;
    logic [3:0] w_len_nxt;
    logic [7:0] w_lmask;
    logic [5:0] w_hit;
    logic       w_any;
    logic       w_full;
    logic [2:0] w_idx;
    logic [7:0] w_sym;

    assign w_hc_in[0] = HC1;
    assign w_hc_in[1] = HC2;
    assign w_hc_in[2] = HC3;
    assign w_hc_in[3] = HC4;
    assign w_hc_in[4] = HC5;
    assign w_hc_in[5] = HC6;
    assign w_m_in[0]  = M1;
    assign w_m_in[1]  = M2;
    assign w_m_in[2]  = M3;
    assign w_m_in[3]  = M4;
    assign w_m_in[4]  = M5;
    assign w_m_in[5]  = M6;

    // State register: a load always moves to RUN, reset returns to EMPTY.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: only a table load changes state.
    always_comb begin
        w_state_nxt = r_state;
        if (code_valid) begin
            w_state_nxt = S_RUN;
        end
    end

    // A bit is consumed only while decoding and not shadowed by a load.
    assign w_shift   = (r_state == S_RUN) && bit_valid && !code_valid;
    assign w_acc_nxt = {r_acc[6:0], bit_in};
    assign w_len_nxt = r_len + 4'd1;
    assign w_lmask   = 8'hFF >> (4'd8 - w_len_nxt);
    assign w_full    = (w_len_nxt == 4'd8);

    // Entry match: mask must equal the length mask, so malformed masks
    // (including zero) can never hit.
    always_comb begin
        w_hit = 6'd0;
        for (int k = 0; k < 6; k++) begin
            w_hit[k] = (r_m[k] == w_lmask) &&
                       ((w_acc_nxt & r_m[k]) == (r_hc[k] & r_m[k]));
        end
    end

    assign w_any = |w_hit;

    // Priority select: scan from the top so the lowest index wins.
    always_comb begin
        w_idx = 3'd0;
        for (int k = 5; k >= 0; k--) begin
            if (w_hit[k]) begin
                w_idx = 3'(k);
            end
        end
    end

    assign w_sym = {5'd0, w_idx} + 8'd1;

    // Code table capture on load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 6; k++) begin
                r_hc[k] <= 8'd0;
                r_m[k]  <= 8'd0;
            end
        end else if (code_valid) begin
            for (int k = 0; k < 6; k++) begin
                r_hc[k] <= w_hc_in[k];
                r_m[k]  <= w_m_in[k];
            end
        end
    end

    // Bit accumulator: shift in, clear on load, hit or overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc <= 8'd0;
            r_len <= 4'd0;
        end else if (code_valid) begin
            r_acc <= 8'd0;
            r_len <= 4'd0;
        end else if (w_shift) begin
            if (w_any || w_full) begin
                r_acc <= 8'd0;
                r_len <= 4'd0;
            end else begin
                r_acc <= w_acc_nxt;
                r_len <= w_len_nxt;
            end
        end
    end

    // Result pulses: one cycle after the deciding bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sym_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_sym_valid <= w_shift && w_any;
            r_err       <= w_shift && !w_any && w_full;
        end
    end

    // Symbol holding register: updated only on a hit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sym_out <= 8'd0;
        end else if (w_shift && w_any) begin
            r_sym_out <= w_sym;
        end
    end

    // Decoded-symbol counter: cleared by a load, wraps naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sym_cnt <= 8'd0;
        end else if (code_valid) begin
            r_sym_cnt <= 8'd0;
        end else if (w_shift && w_any) begin
            r_sym_cnt <= r_sym_cnt + 8'd1;
        end
    end

    assign table_ok  = (r_state == S_RUN);
    assign sym_valid = r_sym_valid;
    assign err       = r_err;
    assign sym_out   = r_sym_out;
    assign sym_cnt   = r_sym_cnt;

endmodule

// File: tb/tb_huffman_dec.sv
// Bench for huffman_dec: directed scenarios plus random traffic,
// all compared against a bit-string reference model.
module tb_huffman_dec;

    logic       clk = 1'b0;
    logic       reset;
    logic       code_valid;
    logic       bit_valid;
    logic       bit_in;
    logic [7:0] hc [0:5];
    logic [7:0] m  [0:5];
    logic       table_ok;
    logic       sym_valid;
    logic [7:0] sym_out;
    logic       err;
    logic [7:0] sym_cnt;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit mr;
    int mhc [1:6];
    int mm  [1:6];
    int macc;
    int mlen;
    int esv;
    int eerr;
    int esym;
    int ecnt;

    huffman_dec dut (
        .clk        (clk),
        .reset      (reset),
        .code_valid (code_valid),
        .HC1        (hc[0]),
        .HC2        (hc[1]),
        .HC3        (hc[2]),
        .HC4        (hc[3]),
        .HC5        (hc[4]),
        .HC6        (hc[5]),
        .M1         (m[0]),
        .M2         (m[1]),
        .M3         (m[2]),
        .M4         (m[3]),
        .M5         (m[4]),
        .M6         (m[5]),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .table_ok   (table_ok),
        .sym_valid  (sym_valid),
        .sym_out    (sym_out),
        .err        (err),
        .sym_cnt    (sym_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // code length implied by a mask, 0 if the mask is malformed
    function automatic int code_len(input int mask);
        for (int l = 1; l <= 8; l++) begin
            if (mask == (1 << l) - 1) return l;
        end
        return 0;
    endfunction

    task automatic model_reset();
        mr   = 1'b0;
        macc = 0;
        mlen = 0;
        esv  = 0;
        eerr = 0;
        esym = 0;
        ecnt = 0;
        for (int k = 1; k <= 6; k++) begin
            mhc[k] = 0;
            mm[k]  = 0;
        end
    endtask

    task automatic model_edge(input bit cv, input bit bv, input bit b);
        int hit;
        esv  = 0;
        eerr = 0;
        if (cv) begin
            for (int k = 1; k <= 6; k++) begin
                mhc[k] = int'(hc[k-1]);
                mm[k]  = int'(m[k-1]);
            end
            macc = 0;
            mlen = 0;
            ecnt = 0;
            mr   = 1'b1;
        end else if (mr && bv) begin
            macc = macc * 2 + int'(b);
            mlen = mlen + 1;
            hit  = 0;
            for (int k = 6; k >= 1; k--) begin
                if (code_len(mm[k]) == mlen &&
                    (macc % (1 << mlen)) == (mhc[k] % (1 << mlen)))
                    hit = k;
            end
            if (hit != 0) begin
                esv  = 1;
                esym = hit;
                ecnt = (ecnt + 1) % 256;
                macc = 0;
                mlen = 0;
            end else if (mlen == 8) begin
                eerr = 1;
                macc = 0;
                mlen = 0;
            end
        end
    endtask

    task automatic check_all(input string p);
        chk({p, "_table_ok"}, int'(table_ok), int'(mr));
        chk({p, "_sym_valid"}, int'(sym_valid), esv);
        chk({p, "_err"}, int'(err), eerr);
        chk({p, "_sym_out"}, int'(sym_out), esym);
        chk({p, "_sym_cnt"}, int'(sym_cnt), ecnt);
    endtask

    task automatic step(input bit cv, input bit bv, input bit b);
        code_valid = cv;
        bit_valid  = bv;
        bit_in     = b;
        model_edge(cv, bv, b);
        @(posedge clk);
        #1;
        check_all("step");
        code_valid = 1'b0;
        bit_valid  = 1'b0;
        bit_in     = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        model_reset();
        check_all("rst");
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic set_table(input int h1, h2, h3, h4, h5, h6,
                             input int k1, k2, k3, k4, k5, k6);
        hc[0] = 8'(h1); hc[1] = 8'(h2); hc[2] = 8'(h3);
        hc[3] = 8'(h4); hc[4] = 8'(h5); hc[5] = 8'(h6);
        m[0]  = 8'(k1); m[1]  = 8'(k2); m[2]  = 8'(k3);
        m[3]  = 8'(k4); m[4]  = 8'(k5); m[5]  = 8'(k6);
    endtask

    task automatic table_a();
        set_table(0, 2, 6, 14, 30, 31, 1, 3, 7, 15, 31, 31);
    endtask

    task automatic send(input int n, input int bits);
        for (int i = n - 1; i >= 0; i--) step(1'b0, 1'b1, bits[i]);
    endtask

    initial begin
        reset      = 1'b1;
        code_valid = 1'b0;
        bit_valid  = 1'b0;
        bit_in     = 1'b0;
        set_table(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset = 1'b0;

        // single-bit code
        table_a();
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("r028_valid", int'(sym_valid), 1);
        chk("r028_sym", int'(sym_out), 1);
        chk("r028_cnt", int'(sym_cnt), 1);

        // three codes of different lengths
        step(1'b1, 1'b0, 1'b0);
        send(2, 2);
        chk("r029_a", int'(sym_out), 2);
        send(5, 31);
        chk("r029_b", int'(sym_out), 6);
        send(3, 6);
        chk("r029_c", int'(sym_out), 3);
        chk("r029_cnt", int'(sym_cnt), 3);

        // no match after eight bits
        set_table(1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1);
        step(1'b1, 1'b0, 1'b0);
        send(8, 0);
        chk("r030_err", int'(err), 1);
        chk("r030_valid", int'(sym_valid), 0);
        send(1, 1);
        chk("r030_clr", int'(sym_valid), 1);

        // no table: bits ignored; load wins over a same-cycle bit
        do_reset();
        send(3, 5);
        chk("r031_tok0", int'(table_ok), 0);
        table_a();
        step(1'b1, 1'b1, 1'b0);
        chk("r031_tok1", int'(table_ok), 1);
        chk("r031_drop", int'(sym_valid), 0);

        // reset discards a partial code
        send(2, 3);
        do_reset();
        send(1, 0);
        chk("r032_idle", int'(sym_valid), 0);
        table_a();
        step(1'b1, 1'b0, 1'b0);
        send(1, 0);
        chk("r032_sym", int'(sym_out), 1);

        // overlapping entries: lowest index wins
        set_table(0, 0, 5, 5, 5, 5, 1, 1, 7, 7, 7, 7);
        step(1'b1, 1'b0, 1'b0);
        send(1, 0);
        chk("r033_sym", int'(sym_out), 1);

        // random traffic
        for (int t = 0; t < 4000; t++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else if (t % 400 == 0 || $urandom_range(0, 99) == 0) begin
                for (int k = 0; k < 6; k++) begin
                    if ($urandom_range(0, 9) == 0)
                        m[k] = 8'($urandom);
                    else
                        m[k] = 8'((1 << $urandom_range(1, 8)) - 1);
                    hc[k] = 8'($urandom);
                end
                step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom));
            end else begin
                step(1'b0, 1'($urandom_range(0, 4) != 0), 1'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
